serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
- Upstream stage for the N-bit palindrome checker. It deserializes a framed serial bit stream into N-bit words and presents each complete word on a valid/ready handshake.
- The checker consumes word_out combinationally while word_valid is high.
- The block detects malformed frames (bit with no start marker, restart mid-frame) and flags them without stalling the stream.

Parameters:
- N, 8: word width in bits; legal range 2..64.
- MSB_FIRST, 1: 1 = first serial bit of a frame lands in word_out[N-1]; 0 = first bit lands in word_out[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin_valid  input  1  a serial bit is offered this cycle.
- sin_data  input  1  serial bit value.
- sin_start  input  1  marks the offered bit as the first bit of a frame; qualified by sin_valid.
- sin_ready  output  1  collector accepts the offered bit this cycle.
- word_out  output  N  assembled word; stable while word_valid=1.
- word_valid  output  1  word_out holds a complete frame.
- word_ready  input  1  downstream accepts word_out this cycle.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Bit accept = sin_valid & sin_ready. Word transfer = word_valid & word_ready.
- Reset (async assert, sync release):
  - state=IDLE, bit count=0, shift register=0.
  - word_out=0, word_valid=0, frame_err=0.
  - sin_ready is combinational and reads 1 in IDLE.
- Bit count width is clog2(N+1).
- IDLE: sin_ready=1.
  - Accepted bit with sin_start=1: shift register gets the first bit, count=1, go to SHIFT.
  - Accepted bit with sin_start=0: bit dropped, frame_err=1 next cycle, stay IDLE.
- SHIFT: sin_ready=1.
  - Each accepted bit shifts in. MSB_FIRST=1: reg <= {reg[N-2:0], bit}. MSB_FIRST=0: reg <= {bit, reg[N-1:1]}.
  - count increments on every accepted bit.
  - Accepted bit with sin_start=1 (restart mid-frame): partial frame discarded; this bit becomes bit 1, count=1; frame_err pulses next cycle; stay SHIFT.
  - Accepting the Nth bit (count==N-1 before the accept): load word_out with the completed word, word_valid=1 next cycle, go to FULL. Latency from Nth bit accept to word_valid is 1 clock.
  - sin_valid=0 cycles are idle gaps; count holds. There is no timeout.
- FULL: word_valid=1, word_out held; sin_ready = word_ready (combinational path, documented).
  - word_ready=0: nothing accepted, hold indefinitely.
  - word_ready=1 and no accepted bit: word transfers, word_valid=0 next cycle, go to IDLE.
  - word_ready=1 with an accepted bit and sin_start=1: word transfers and the new frame starts in the same cycle (count=1, go to SHIFT); no bubble.
  - word_ready=1 with an accepted bit and sin_start=0: word transfers, bit dropped, frame_err pulses, go to IDLE.
- word_out changes only on the FULL load; it keeps its last value after the transfer. Downstream must qualify with word_valid.
- frame_err is registered, exactly 1 cycle per offending bit; back-to-back errors give back-to-back pulses.
- Reset mid-frame or in FULL: partial or held data is lost; all outputs return to their reset values immediately.
- sin_start / sin_data are don't-care when sin_valid=0.

Test Plan:
- Reset, N=8, MSB_FIRST=1; send 1,0,1,0,0,1,0,1 with start on bit 1, word_ready=1 -> word_valid high exactly 1 cycle after the 8th bit; word_out=8'hA5; one-cycle valid; back to IDLE.
- Same frame with MSB_FIRST=0, bits 1,1,0,0,0,0,0,0 -> word_out=8'h03.
- Frame 8'hF0 complete, word_ready=0 for 5 cycles while sin_valid=1 -> sin_ready=0, word_out=8'hF0 stable throughout. Then word_ready=1 with a start bit -> transfer and new frame begin in the same cycle; the second frame 8'h81 appears with no lost bit.
- Start, 3 bits, then sin_start=1 on the next bit -> frame_err pulses once; next 8 bits from the restart yield their exact word (e.g. 8'h3C); the partial bits do not appear.
- Bits with sin_valid=1, sin_start=0 in IDLE (3 bits) -> 3 frame_err pulses; word_valid stays 0.
- Assert rst asynchronously (mid-cycle) after 5 bits, and separately while FULL -> word_valid=0, frame_err=0, word_out=0 immediately; a fresh 8'h5A frame after release is collected correctly.

Source files
------------

// File: rtl/serial_word_collector.sv
// Purpose: deserializes a framed serial bit stream into N-bit words on a valid/ready output.
// Latency: word_valid rises 1 clock after the Nth bit of a frame is accepted.
// Backpressure: while a word is held, sin_ready follows word_ready combinationally; errors never stall.
module serial_word_collector #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin_valid,
  input  logic         sin_data,
  input  logic         sin_start,
  output logic         sin_ready,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         frame_err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [N-1:0]   sreg, sreg_n;
  logic [N-1:0]   word_n;
  logic           err_n;
  logic           accept;
  logic [N-1:0]   first_word;
  logic [N-1:0]   shifted_word;

  // In FULL the upstream may only advance when the held word leaves this cycle.
  assign sin_ready  = (state == FULL) ? word_ready : 1'b1;
  assign accept     = sin_valid & sin_ready;
  assign word_valid = (state == FULL);

  // A start bit clears any stale bits so the partial frame never leaks into the word.
  assign first_word   = (MSB_FIRST != 0) ? {{(N-1){1'b0}}, sin_data} : {sin_data, {(N-1){1'b0}}};
  assign shifted_word = (MSB_FIRST != 0) ? {sreg[N-2:0], sin_data} : {sin_data, sreg[N-1:1]};

  // Next-state, counter, shift register and error decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    word_n  = word_out;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sin_start) begin
            sreg_n  = first_word;
            cnt_n   = CW'(1);
            state_n = SHIFT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          if (sin_start) begin
            // Restart mid-frame: this bit becomes bit 1 of a new frame.
            sreg_n = first_word;
            cnt_n  = CW'(1);
            err_n  = 1'b1;
          end else if (cnt == CW'(N - 1)) begin
            sreg_n  = shifted_word;
            word_n  = shifted_word;
            cnt_n   = '0;
            state_n = FULL;
          end else begin
            sreg_n = shifted_word;
            cnt_n  = cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (word_ready) begin
          state_n = IDLE;
          if (accept) begin
            if (sin_start) begin
              // Hand-off and next frame start in the same cycle, no bubble.
              sreg_n  = first_word;
              cnt_n   = CW'(1);
              state_n = SHIFT;
            end else begin
              err_n = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      word_out  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sreg      <= sreg_n;
      word_out  <= word_n;
      frame_err <= err_n;
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: an MSB-first and an LSB-first instance share one stimulus.
// Constant vector table, hand-written corner sequences, then random traffic against a queue model.
module tb_serial_word_collector;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin_valid, sin_data, sin_start, word_ready;
  logic         sin_ready_m, word_valid_m, frame_err_m;
  logic         sin_ready_l, word_valid_l, frame_err_l;
  logic [N-1:0] word_out_m, word_out_l;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  serial_word_collector #(.N(N), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
    .sin_ready(sin_ready_m), .word_out(word_out_m), .word_valid(word_valid_m),
    .word_ready(word_ready), .frame_err(frame_err_m)
  );

  serial_word_collector #(.N(N), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
    .sin_ready(sin_ready_l), .word_out(word_out_l), .word_valid(word_valid_l),
    .word_ready(word_ready), .frame_err(frame_err_l)
  );

  // Reference model: a frame is just the list of bits collected since its start marker.
  bit           mq[$];
  bit           m_in_frame, m_full, m_err;
  logic [N-1:0] m_wmsb, m_wlsb;

  typedef struct {
    logic v, d, s, wr;
    logic e_rdy, e_vld, e_err;
    logic [N-1:0] e_msb, e_lsb;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_in_frame = 0; m_full = 0; m_err = 0;
    m_wmsb = '0; m_wlsb = '0;
  endtask

  task automatic model_update(input logic v, input logic d, input logic s, input logic wr);
    bit acc, nerr;
    acc  = v && (m_full ? wr : 1'b1);
    nerr = 0;
    if (m_full && wr) m_full = 0;
    if (acc) begin
      if (s) begin
        if (m_in_frame) nerr = 1;
        mq.delete();
        mq.push_back(d);
        m_in_frame = 1;
      end else if (m_in_frame) begin
        mq.push_back(d);
        if (mq.size() == N) begin
          for (int i = 0; i < N; i++) begin
            m_wmsb[N-1-i] = mq[i];
            m_wlsb[i]     = mq[i];
          end
          m_full = 1; m_in_frame = 0;
          mq.delete();
        end
      end else begin
        nerr = 1;
      end
    end
    m_err = nerr;
  endtask

  task automatic drive(input logic v, input logic d, input logic s, input logic wr);
    @(negedge clk);
    sin_valid = v; sin_data = d; sin_start = s; word_ready = wr;
    #1;
    if (frame_err_m) err_seen++;
  endtask

  // One cycle checked against the model, then the model advances across the edge.
  task automatic step(input logic v, input logic d, input logic s, input logic wr);
    logic e_rdy;
    drive(v, d, s, wr);
    e_rdy = m_full ? wr : 1'b1;
    chk("sin_ready", {sin_ready_m, sin_ready_l}, {e_rdy, e_rdy});
    chk("word_valid", {word_valid_m, word_valid_l}, {m_full, m_full});
    chk("word_out_msb", word_out_m, m_wmsb);
    chk("word_out_lsb", word_out_l, m_wlsb);
    chk("frame_err", {frame_err_m, frame_err_l}, {m_err, m_err});
    model_update(v, d, s, wr);
  endtask

  // Sends a byte oldest-bit-first as b[7]..b[0], start marker on the first bit.
  task automatic send_frame(input logic [N-1:0] b, input logic wr);
    for (int i = N - 1; i >= 0; i--) step(1'b1, b[i], (i == N - 1), wr);
  endtask

  // Asserts rst between clock edges and checks the outputs clear without waiting for an edge.
  task automatic async_reset(input string nm);
    #2;
    rst = 1'b1;
    #1;
    chk({nm, "_vld"}, {word_valid_m, word_valid_l}, 2'b00);
    chk({nm, "_err"}, {frame_err_m, frame_err_l}, 2'b00);
    chk({nm, "_word"}, {word_out_m, word_out_l}, '0);
    chk({nm, "_rdy"}, {sin_ready_m, sin_ready_l}, 2'b11);
    @(negedge clk);
    sin_valid = 0; sin_start = 0; sin_data = 0; word_ready = 0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add_row(input logic v, d, s, wr, e_rdy, e_vld, e_err,
                         input logic [N-1:0] e_msb, e_lsb);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.wr = wr;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_err = e_err; r.e_msb = e_msb; r.e_lsb = e_lsb;
    tbl.push_back(r);
  endtask

  initial begin
    logic [N-1:0] a5, c0;
    logic [N-1:0] bv;
    a5 = 8'hA5;
    c0 = 8'hC0;
    rst = 1'b1; sin_valid = 0; sin_data = 0; sin_start = 0; word_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Frame A5 (bit-symmetric, so both orders give A5), one-cycle valid with word_ready=1.
    for (int i = N - 1; i >= 0; i--) add_row(1, a5[i], (i == N - 1), 1, 1, 0, 0, 8'h00, 8'h00);
    add_row(0, 0, 0, 1, 1, 1, 0, 8'hA5, 8'hA5);
    add_row(0, 0, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
    // Bits 1,1,0,0,0,0,0,0: MSB-first C0, LSB-first 03; held one cycle with word_ready=0.
    for (int i = N - 1; i >= 0; i--) add_row(1, c0[i], (i == N - 1), 1, 1, 0, 0, 8'hA5, 8'hA5);
    add_row(0, 0, 0, 0, 0, 1, 0, 8'hC0, 8'h03);
    add_row(0, 0, 0, 1, 1, 1, 0, 8'hC0, 8'h03);
    add_row(0, 0, 0, 1, 1, 0, 0, 8'hC0, 8'h03);
    // Three unframed bits in IDLE: three back-to-back error pulses, each one cycle late.
    add_row(1, 1, 0, 1, 1, 0, 0, 8'hC0, 8'h03);
    add_row(1, 0, 0, 1, 1, 0, 1, 8'hC0, 8'h03);
    add_row(1, 1, 0, 1, 1, 0, 1, 8'hC0, 8'h03);
    add_row(0, 0, 0, 1, 1, 0, 1, 8'hC0, 8'h03);
    add_row(0, 0, 0, 1, 1, 0, 0, 8'hC0, 8'h03);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].s, tbl[k].wr);
      chk($sformatf("tbl%0d_rdy", k), {sin_ready_m, sin_ready_l}, {tbl[k].e_rdy, tbl[k].e_rdy});
      chk($sformatf("tbl%0d_vld", k), {word_valid_m, word_valid_l}, {tbl[k].e_vld, tbl[k].e_vld});
      chk($sformatf("tbl%0d_err", k), {frame_err_m, frame_err_l}, {tbl[k].e_err, tbl[k].e_err});
      chk($sformatf("tbl%0d_msb", k), word_out_m, tbl[k].e_msb);
      chk($sformatf("tbl%0d_lsb", k), word_out_l, tbl[k].e_lsb);
      model_update(tbl[k].v, tbl[k].d, tbl[k].s, tbl[k].wr);
    end

    // Backpressure: F0 held for 5 cycles with bits offered, then same-cycle hand-off into 81.
    send_frame(8'hF0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      chk("bp_rdy", sin_ready_m, 1'b0);
      chk("bp_word", word_out_m, 8'hF0);
    end
    send_frame(8'h81, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("handoff_word", {word_out_m, word_out_l}, {8'h81, 8'h81});
    chk("handoff_vld", word_valid_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Restart mid-frame: one error pulse, only the restarted frame is delivered.
    err_seen = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_word", {word_out_m, word_out_l}, {8'h3C, 8'h3C});
    chk("restart_errs", err_seen, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset after 5 bits, then reset while holding a word, then a clean 5A frame.
    bv = 8'h77;
    for (int i = N - 1; i >= N - 5; i--) step(1'b1, bv[i], (i == N - 1), 1'b1);
    async_reset("rst_mid");
    send_frame(8'h11, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_full", word_valid_m, 1'b1);
    async_reset("rst_full");
    send_frame(8'h5A, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_word", {word_out_m, word_out_l}, {8'h5A, 8'h5A});
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
